spike_aer_encoder: RTL and testbench
====================================

# spike_aer_encoder

Downstream consumer of the `lif` neuron stage: takes the 4-bit per-cycle spike vector (one bit per neuron channel) and serializes it into address-event (AER) packets. Each packet carries a 2-bit channel address and a timestamp, and is buffered in a small FIFO. Packets leave on a valid/ready stream toward the output pins or the next processing stage. Overload is reported through a sticky flag and a drop counter.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `TS_W`, 8: timestamp width in bits.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `spikes_in`  in  4: spike vector from the `lif` stage; bit i = channel i.
- `spikes_valid`  in  1: `spikes_in` is a valid sample this cycle.
- `evt_valid`  out  1: head packet available.
- `evt_ready`  in  1: consumer accepts the packet.
- `evt_addr`  out  2: channel index of the head packet.
- `evt_ts`  out  TS_W: timestamp of the head packet.
- `overflow`  out  1: sticky; set when any spike is dropped.
- `drop_count`  out  8: count of dropped spikes, saturating at 255.
- `busy`  out  1: pending register nonzero or FIFO non-empty.

## Operation
- **Timestamp counter `ts`.** Free-running, increments every cycle, wraps from 2^TS_W−1 to 0.
- **Pending register.** Holds a vector `pend[3:0]` and its timestamp `pend_ts`.
- **Capture.** A sample is captured when `spikes_valid`=1, `spikes_in`≠0, and the capture slot is free.
  - The slot is free when `pend`=0, or when `pend` has exactly one bit set and that bit is pushed this cycle.
  - On capture: `pend`←`spikes_in`, `pend_ts`←current `ts`.
- **Ignored samples.** If `spikes_valid`=1 and `spikes_in`=0, nothing happens: no capture, no drop.
- **Dropped samples.** If `spikes_valid`=1, `spikes_in`≠0 and the slot is not free, the sample is discarded.
  - `drop_count` += popcount(`spikes_in`), saturating at 255.
  - `overflow`←1 and stays set until `rst`.
- **Serializer.** Each cycle it may push at most one packet, {index of the lowest set bit of `pend`, `pend_ts`}.
  - A push is allowed when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - On push, that bit of `pend` is cleared. Channels are emitted in ascending index order.
- **FIFO.** `DEPTH` entries of {addr, ts}. Push and pop in the same cycle are legal at any occupancy. An occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- **Output stream.**
  - `evt_valid` = FIFO non-empty; `evt_addr`/`evt_ts` present the head entry.
  - Pop occurs when `evt_valid` & `evt_ready`.
  - While `evt_valid`=1 and `evt_ready`=0, `evt_addr`/`evt_ts` hold stable.
  - While `evt_valid`=0, `evt_addr`/`evt_ts` are driven 0.
- **Reset mid-operation.** Pending and FIFO contents are discarded. No partial packet is emitted afterward.

## Timing
- **Reset values.** `evt_valid`=0, `evt_addr`=0, `evt_ts`=0, `overflow`=0, `drop_count`=0, `busy`=0; internal `ts`=0, `pend`=0, FIFO empty.
- **Latency.** Sample accepted in cycle N → `pend` loaded at the end of N → first packet pushed in N+1 → `evt_valid`=1 in N+2 (FIFO empty, `evt_ready`=1).
- **Throughput.** Up to one packet per cycle. Popcount k costs k serializer cycles.
- **Back-to-back samples.** Sustained only for single-spike vectors. A k-spike vector blocks capture for k−1 cycles.
- **Timestamps.** `evt_ts` equals `ts` in the capture cycle, identical for all packets of one vector.
- **`busy`.** Combinational from registered state.
- **Saturation.** `drop_count` at 255 stays at 255.

## Test plan
- **Basic serialization.** After reset, hold `evt_ready`=1. At `ts`=5, present `spikes_in`=4'b1011 with `spikes_valid`=1 → packets (addr,ts) = (0,5),(1,5),(3,5) on three consecutive cycles, starting 2 cycles later. Then `busy`=0.
- **Backpressure and full.**
  - With `DEPTH`=8 and `evt_ready`=0, send 4'b1111 on cycles 0, 4 and 8 → FIFO full after 8 pushes with `pend`=0; the third vector is captured into `pend` and stalls.
  - A fourth vector 4'b0011 → `drop_count`=2, `overflow`=1.
  - Raise `evt_ready` → 12 packets drain in order with ts values 0, 4, 8, and data stays stable across stalls.
- **Simultaneous push/pop at full.** With the FIFO full, `evt_ready`=1 and `pend`≠0 → occupancy stays 8 every cycle, no drops, ordering preserved.
- **Zero vector and wrap.**
  - `spikes_valid`=1 with `spikes_in`=0 → no packet, `drop_count` unchanged.
  - Sample at `ts`=255 and again at `ts`=0 → `evt_ts` 255, then 0.
- **Saturation.** Drive 70 dropped 4'b1111 vectors while stalled → `drop_count`=255 and holds there.
- **Reset mid-stream.** With `pend`=4'b1100 and the FIFO holding 3 entries, assert `rst` for 1 cycle → next cycle all outputs at reset values and no stale packet appears afterward.

Source files
------------

// File: rtl/spike_aer_encoder.sv
// Spike-vector to address-event (AER) serializer.
// Captures 4-bit spike vectors from the LIF stage with a timestamp. It emits one
// {channel, timestamp} packet per set bit, in ascending channel order, into a small
// FIFO that drains over a valid/ready stream. Samples that arrive while the capture
// slot is still busy are dropped, and their spikes are counted.
module spike_aer_encoder #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      spikes_in,
  input  logic            spikes_valid,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [1:0]      evt_addr,
  output logic [TS_W-1:0] evt_ts,
  output logic            overflow,
  output logic [7:0]      drop_count,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0] ts;
  logic [3:0]      pend;
  logic [TS_W-1:0] pend_ts;

  logic [1:0]      mem_addr [DEPTH];
  logic [TS_W-1:0] mem_ts   [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic       full;
  logic       pop;
  logic       push;
  logic [1:0] low_idx;
  logic [3:0] low_bit;
  logic       single;
  logic       slot_free;
  logic       sample_hot;
  logic       capture;
  logic       drop;
  logic [2:0] spike_pop;
  logic [8:0] drop_sum;

  // Serializer selection, capture/drop decisions and output presentation.
  always_comb begin
    low_idx = 2'd0;
    if (pend[0])      low_idx = 2'd0;
    else if (pend[1]) low_idx = 2'd1;
    else if (pend[2]) low_idx = 2'd2;
    else if (pend[3]) low_idx = 2'd3;
    low_bit = 4'b0001 << low_idx;

    full      = (count == (AW+1)'(DEPTH));
    evt_valid = (count != '0);
    pop       = evt_valid && evt_ready;
    push      = (pend != 4'd0) && (!full || pop);

    single     = (pend != 4'd0) && ((pend & (pend - 4'd1)) == 4'd0);
    slot_free  = (pend == 4'd0) || (single && push);
    sample_hot = spikes_valid && (spikes_in != 4'd0);
    capture    = sample_hot && slot_free;
    drop       = sample_hot && !slot_free;

    spike_pop = {2'b00, spikes_in[0]} + {2'b00, spikes_in[1]}
              + {2'b00, spikes_in[2]} + {2'b00, spikes_in[3]};
    drop_sum  = {1'b0, drop_count} + {6'd0, spike_pop};

    evt_addr = evt_valid ? mem_addr[rd_ptr] : 2'd0;
    evt_ts   = evt_valid ? mem_ts[rd_ptr]   : '0;
    busy     = (pend != 4'd0) || evt_valid;
  end

  // Free-running timestamp, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  // Pending vector: a fresh capture replaces it, otherwise each push retires the lowest bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 4'd0;
      pend_ts <= '0;
    end else if (capture) begin
      pend    <= spikes_in;
      pend_ts <= ts;
    end else if (push) begin
      pend    <= pend & ~low_bit;
    end
  end

  // FIFO pointers and occupancy; the extra occupancy bit separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset because the outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= low_idx;
      mem_ts[wr_ptr]   <= pend_ts;
    end
  end

  // Overload reporting: a sticky flag and a saturating dropped-spike count.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= drop_sum[8] ? 8'd255 : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed testbench for spike_aer_encoder: a per-cycle vector table, then
// hand-written sequences for backpressure, full-FIFO push/pop, timestamp wrap,
// drop-count saturation and mid-stream reset.
module tb_spike_aer_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] spikes_in;
  logic       spikes_valid;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_addr;
  logic [7:0] evt_ts;
  logic       overflow;
  logic [7:0] drop_count;
  logic       busy;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    logic [3:0] spk;
    logic       sv;
    logic       rdy;
    logic       ev;
    logic [1:0] addr;
    logic [7:0] ts;
    logic       bsy;
  } vec_t;

  vec_t tbl[16];

  typedef struct {
    logic [1:0] addr;
    logic [7:0] ts;
  } pkt_t;

  pkt_t exp_pkts[13];

  spike_aer_encoder #(.DEPTH(8), .TS_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .spikes_in(spikes_in),
    .spikes_valid(spikes_valid),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_addr(evt_addr),
    .evt_ts(evt_ts),
    .overflow(overflow),
    .drop_count(drop_count),
    .busy(busy)
  );

  // Free-running 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_output(input string name, input logic ev, input logic [1:0] addr,
                              input logic [7:0] ts, input logic bsy);
    check_val({name, ".evt_valid"}, int'(evt_valid), int'(ev));
    check_val({name, ".evt_addr"},  int'(evt_addr),  int'(addr));
    check_val({name, ".evt_ts"},    int'(evt_ts),    int'(ts));
    check_val({name, ".busy"},      int'(busy),      int'(bsy));
  endtask

  // Drive one cycle of inputs, advance past the rising edge and settle.
  task automatic apply_stimulus(input logic [3:0] spk, input logic sv, input logic rdy,
                                input logic r);
    spikes_in    = spk;
    spikes_valid = sv;
    evt_ready    = rdy;
    rst          = r;
    @(posedge clk);
    #1;
    if (r) cyc = 0;
    else   cyc++;
  endtask

  task automatic do_reset();
    apply_stimulus(4'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  // Fill an 8-deep FIFO with three 4-spike vectors at ts 0, 4, 8 while stalled.
  task automatic fill_stalled();
    for (int c = 0; c < 9; c++) begin
      if (c == 0 || c == 4 || c == 8) apply_stimulus(4'b1111, 1'b1, 1'b0, 1'b0);
      else                            apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    rst = 1'b1;
    spikes_in = 4'd0;
    spikes_valid = 1'b0;
    evt_ready = 1'b0;

    for (int i = 0; i < 5; i++) tbl[i] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0};
    tbl[5]  = '{4'b1011, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0,  1'b1};
    tbl[6]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 8'd5,  1'b1};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 8'd5,  1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 8'd5,  1'b1};
    tbl[9]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0};
    tbl[12] = '{4'b0100, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0,  1'b1};
    tbl[13] = '{4'b0001, 1'b1, 1'b1, 1'b1, 2'd2, 8'd12, 1'b1};
    tbl[14] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 8'd13, 1'b1};
    tbl[15] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0};

    // Reset values
    do_reset();
    check_output("reset", 1'b0, 2'd0, 8'd0, 1'b0);
    check_val("reset.overflow", int'(overflow), 0);
    check_val("reset.drop_count", int'(drop_count), 0);

    // Table: basic serialization, zero vector, back-to-back single spikes
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(tbl[i].spk, tbl[i].sv, tbl[i].rdy, 1'b0);
      check_output($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].addr, tbl[i].ts, tbl[i].bsy);
      check_val($sformatf("tbl[%0d].drop_count", i), int'(drop_count), 0);
      check_val($sformatf("tbl[%0d].overflow", i), int'(overflow), 0);
    end

    // Backpressure, full FIFO, drop, then drain with push/pop at full
    do_reset();
    fill_stalled();
    check_val("bp.drop_after_fill", int'(drop_count), 0);
    apply_stimulus(4'b0011, 1'b1, 1'b0, 1'b0);
    check_val("bp.drop_count", int'(drop_count), 2);
    check_val("bp.overflow", int'(overflow), 1);
    check_output("bp.head", 1'b1, 2'd0, 8'd0, 1'b1);
    for (int s = 0; s < 2; s++) begin
      apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      check_output($sformatf("bp.stall%0d", s), 1'b1, 2'd0, 8'd0, 1'b1);
    end
    for (int j = 0; j < 12; j++) exp_pkts[j] = '{2'(j % 4), 8'(4 * (j / 4))};
    exp_pkts[12] = '{2'd0, 8'(cyc + 3)};
    for (int j = 0; j < 13; j++) begin
      check_output($sformatf("drain[%0d]", j), 1'b1, exp_pkts[j].addr, exp_pkts[j].ts, 1'b1);
      apply_stimulus(4'b0001, (j == 3), 1'b1, 1'b0);
    end
    check_output("drain.end", 1'b0, 2'd0, 8'd0, 1'b0);
    check_val("drain.drop_count", int'(drop_count), 2);
    check_val("drain.overflow", int'(overflow), 1);

    // Timestamp wrap: samples at ts 255 and ts 0
    do_reset();
    while (cyc < 255) apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b0);
    apply_stimulus(4'b0010, 1'b1, 1'b1, 1'b0);
    check_output("wrap.first", 1'b1, 2'd0, 8'd255, 1'b1);
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    check_output("wrap.second", 1'b1, 2'd1, 8'd0, 1'b1);
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    check_output("wrap.empty", 1'b0, 2'd0, 8'd0, 1'b0);

    // Drop-count saturation while stalled
    do_reset();
    fill_stalled();
    for (int n = 1; n <= 70; n++) begin
      apply_stimulus(4'b1111, 1'b1, 1'b0, 1'b0);
      check_val($sformatf("sat[%0d]", n), int'(drop_count), (4 * n > 255) ? 255 : 4 * n);
    end
    check_val("sat.overflow", int'(overflow), 1);

    // Reset mid-stream with pend=1100 and three FIFO entries
    do_reset();
    apply_stimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    apply_stimulus(4'b1111, 1'b1, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    check_output("mid.before", 1'b1, 2'd0, 8'd0, 1'b1);
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b1);
    check_output("mid.reset", 1'b0, 2'd0, 8'd0, 1'b0);
    check_val("mid.overflow", int'(overflow), 0);
    check_val("mid.drop_count", int'(drop_count), 0);
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      check_output($sformatf("mid.after%0d", k), 1'b0, 2'd0, 8'd0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
